// File: rtl/datapath_defs.sv
// Shared datapath constants: widths, ALU opcodes and sequencer state encoding.
// Reused by the register-sum sequencer and the main/ALU control decoders.
package datapath_defs;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int MEM_AW_DEF = 7;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ACCUM = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/reg_sum_controller.sv
// Sequencer that sums a block of registers into an accumulator via the
// shared datapath, then stores the result to data memory.
module reg_sum_controller
    import datapath_defs::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int MEM_AW = MEM_AW_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [REG_AW-1:0] first_reg,
    input  logic [REG_AW-1:0] count,
    input  logic [REG_AW-1:0] acc_reg,
    input  logic [MEM_AW-1:0] mem_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [REG_AW-1:0] ReadReg1,
    output logic [REG_AW-1:0] ReadReg2,
    output logic [REG_AW-1:0] WriteReg,
    output logic              RegWrite,
    output logic              ALUSrc,
    output logic [DATA_W-1:0] Immediate,
    output logic [3:0]        ALUCtl,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [MEM_AW-1:0] address
);

    logic [2:0]        state_q, state_d;
    logic [REG_AW-1:0] idx_q, idx_d;
    logic [REG_AW-1:0] first_q, first_d;
    logic [REG_AW-1:0] count_q, count_d;
    logic [REG_AW-1:0] acc_q, acc_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              err_q, err_d;

    // Block must fit in the file and must not overlap the accumulator.
    function automatic logic args_ok(
        input logic [REG_AW-1:0] f,
        input logic [REG_AW-1:0] c,
        input logic [REG_AW-1:0] a
    );
        logic [REG_AW:0] last;
        last = {1'b0, f} + {1'b0, c} - (REG_AW+1)'(1);
        return (c != '0) && !last[REG_AW] && (a != '0)
            && !((a >= f) && ({1'b0, a} <= last));
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        first_d = first_q;
        count_d = count_q;
        acc_d   = acc_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (args_ok(first_reg, count, acc_reg)) begin
                        first_d = first_reg;
                        count_d = count;
                        acc_d   = acc_reg;
                        addr_d  = mem_addr;
                        idx_d   = '0;
                        state_d = S_CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                idx_d   = '0;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (idx_q == count_q - REG_AW'(1)) begin
                    state_d = S_STORE;
                end else begin
                    idx_d = idx_q + REG_AW'(1);
                end
            end
            S_STORE: state_d = S_DONE;
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            first_q <= '0;
            count_q <= '0;
            acc_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    // Outputs depend only on registered state so reset drops them at once.
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = 1'b0;
        error     = err_q;
        ReadReg1  = '0;
        ReadReg2  = '0;
        WriteReg  = '0;
        RegWrite  = 1'b0;
        ALUSrc    = 1'b0;
        Immediate = '0;
        ALUCtl    = ALU_ADD;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        address   = '0;
        unique case (state_q)
            S_CLEAR: begin
                ALUSrc   = 1'b1;
                WriteReg = acc_q;
                RegWrite = 1'b1;
            end
            S_ACCUM: begin
                ReadReg1 = acc_q;
                ReadReg2 = first_q + idx_q;
                WriteReg = acc_q;
                RegWrite = 1'b1;
            end
            S_STORE: begin
                ReadReg1 = acc_q;
                ReadReg2 = acc_q;
                ALUSrc   = 1'b1;
                MemWrite = 1'b1;
                address  = addr_q;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/reg_sum_controller.md
# reg_sum_controller

Multi-cycle sequencer that drives the shared single-cycle datapath (register file, ALU, ALUSrc mux, data memory) to sum a contiguous block of registers into an accumulator register, then store the result to data memory. It replaces hand-driven control sequencing: one `start` pulse produces the full clear / accumulate / store sequence. It sits between a host/test master and the datapath's control inputs.

## Interface
Parameters:
- `DATA_W`, 32, datapath word width
- `REG_AW`, 5, register index width (32 registers, `$0` hard-wired zero)
- `MEM_AW`, 7, data memory address width

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock, shared with RegFile and DataMemory
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  request, sampled only in IDLE
- `first_reg`  in  REG_AW  first source register index
- `count`  in  REG_AW  number of source registers (1..31)
- `acc_reg`  in  REG_AW  accumulator/destination register
- `mem_addr`  in  MEM_AW  store address
- `busy`  out  1  high from accepted start through DONE
- `done`  out  1  one-cycle pulse, successful completion
- `error`  out  1  one-cycle pulse, request rejected
- `ReadReg1`, `ReadReg2`, `WriteReg`  out  REG_AW  RegFile addresses
- `RegWrite`  out  1  RegFile write enable
- `ALUSrc`  out  1  1 = immediate to ALU B
- `Immediate`  out  DATA_W  immediate operand
- `ALUCtl`  out  4  ALU operation
- `MemWrite`, `MemRead`  out  1  DataMemory strobes
- `address`  out  MEM_AW  DataMemory address

## Operation
- States: IDLE, CLEAR, ACCUM, STORE, DONE.
- IDLE: `start`=1 -> validate; if valid capture `first_reg`, `count`, `acc_reg`, `mem_addr`, go CLEAR; else pulse `error` next cycle, stay IDLE.
- Invalid: `count`==0; `first_reg`+`count`-1 > 31 (5-bit overflow); `acc_reg`==0; `acc_reg` in [`first_reg`, `first_reg`+`count`-1].
- CLEAR (1 cycle): ReadReg1=0, ALUSrc=1, Immediate=0, ALUCtl=ADD, WriteReg=acc, RegWrite=1 -> acc := 0.
- ACCUM (count cycles, index i=0..count-1): ReadReg1=acc, ReadReg2=first+i, ALUSrc=0, ALUCtl=ADD, WriteReg=acc, RegWrite=1. Exit to STORE when i==count-1.
- STORE (1 cycle): ReadReg1=acc, ALUSrc=1, Immediate=0, ALUCtl=ADD, RegWrite=0, MemWrite=1, address=captured mem_addr.
- DONE (1 cycle): `done`=1, all strobes low, -> IDLE.
- Arithmetic: modulo 2^DATA_W, overflow ignored; `Zero` not consumed.
- ALUCtl ADD = 4'b0010; idle/default ALUCtl = ADD.
- MemRead always 0 (reserved).

## Timing
- Reset (async, immediate): state IDLE, i=0; busy, done, error, RegWrite, MemWrite, MemRead, ALUSrc = 0; all addresses, Immediate = 0; ALUCtl = 4'b0010.
- Reset mid-sequence: strobes drop immediately; partially written acc left as is; no store.
- All outputs decoded from registered state/index/captured args only; no combinational input-to-output path.
- Start accepted at edge k -> CLEAR active cycle k+1; busy high cycles k+1 .. k+count+3; done high in cycle k+count+3.
- Total: count+3 cycles from accept to done.
- `start` while busy: ignored, not queued. `start` held high after DONE: re-accepted in next IDLE cycle.
- Error pulse one cycle after the rejecting start; busy stays 0.
- Inputs changing during busy: no effect (captured).

## Structure
- Shared header/package `datapath_defs`: ALU opcode constants (ADD=4'b0010, SUB, AND, OR, SLT), state encoding, register/memory width constants; reused by MainControl/ALUControl.
- Single module; no sub-module needed. Argument validation is a combinational function inside.

## Test plan
- Regs $1..$6 = 5,2,0,5,6,3; start first=1,count=6,acc=31,addr=0 -> $31=21, Mem[0]=21, done 9 cycles after accept, busy 9 cycles.
- count=1, first=4 ($4=5), acc=10, addr=127 -> Mem[127]=5, done after 4 cycles.
- Rejects: count=0; first=30,count=3; acc=0; first=1,count=6,acc=3 -> each one error pulse, no RegWrite/MemWrite, busy 0.
- $1=$2=0xFFFF_FFFF, count=2 -> acc=0xFFFF_FFFE (wrap), stored.
- reset_n low during ACCUM i=2 -> all strobes 0 asynchronously, IDLE, no MemWrite, no done.
- start pulsed during ACCUM with different args -> ignored; original result stored; next start after done accepted.
